video_sram_arbiter: RTL and testbench



---
 rtl/video_sram_arbiter_pkg.sv | 18 +
 rtl/video_rr_picker2.sv | 37 +++
 rtl/video_sram_arbiter.sv | 137 +++++++++++++
 tb/tb_video_sram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_sram_arbiter_pkg.sv
// Shared definitions for the video SRAM port-0 arbiter: state encoding,
// default row width and the macro-select bit position.
package video_sram_arbiter_pkg;

   localparam int VIDEO_SRAM_ADDRESS_SIZE = 9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } arb_state_e;

   // The macro-select bit sits directly above the row bits of a requester address.
   function automatic int macro_sel_bit(input int sram_address_size);
      return sram_address_size;
   endfunction

endpackage

// File: rtl/video_rr_picker2.sv
// Two-way grant picker. With ARBITER_ROUND_ROBIN_EN defined a lastGrant bit
// breaks ties in favour of the other requester; otherwise requester 0 always wins.
module video_rr_picker2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic update_i,
   output logic grant_o,
   output logic any_o
);

   assign any_o = valid0_i | valid1_i;

`ifdef ARBITER_ROUND_ROBIN_EN
   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      if (valid0_i && valid1_i) grant_o = ~last_grant_q;
      else                      grant_o = valid1_i;
   end

   assign last_grant_d = update_i ? grant_o : last_grant_q;

   // Reset to 1 so requester 0 takes the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, clk_i, rst_i, update_i};
   assign grant_o   = valid1_i & ~valid0_i;
`endif

endmodule

// File: rtl/video_sram_arbiter.sv
// Shares SRAM port 0 of the video macro pair between two requesters with an
// IDLE/ACCESS/RESPOND sequencer. Tie-break mode: ARBITER_ROUND_ROBIN_EN.
module video_sram_arbiter
   import video_sram_arbiter_pkg::*;
#(
   parameter int SRAM_ADDRESS_SIZE = VIDEO_SRAM_ADDRESS_SIZE,
   parameter int ADDRESS_BITS      = SRAM_ADDRESS_SIZE + 1
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   // Handshake: reqN_valid is held with stable fields until the one-cycle
   // reqN_ack; fields are latched in IDLE, so they may change after ACCESS.
   input  logic                         req0_valid,
   input  logic                         req0_we,
   input  logic [ADDRESS_BITS-1:0]      req0_address,
   input  logic [3:0]                   req0_wmask,
   input  logic [31:0]                  req0_dataWrite,
   output logic                         req0_ack,
   output logic [31:0]                  req0_dataRead,
   output logic                         req0_busy,
   input  logic                         req1_valid,
   input  logic                         req1_we,
   input  logic [ADDRESS_BITS-1:0]      req1_address,
   input  logic [3:0]                   req1_wmask,
   input  logic [31:0]                  req1_dataWrite,
   output logic                         req1_ack,
   output logic [31:0]                  req1_dataRead,
   output logic                         req1_busy,
   output logic [1:0]                   sram_csb0,
   output logic                         sram_web0,
   output logic [3:0]                   sram_wmask0,
   output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr0,
   output logic [31:0]                  sram_din0,
   input  logic [63:0]                  sram_dout0,
   output logic [1:0]                   dbg_state_o
);

   localparam int MSEL = macro_sel_bit(SRAM_ADDRESS_SIZE);

   arb_state_e                   state_q;
   logic [1:0]                   csb_q;
   logic                         web_q;
   logic [3:0]                   wmask_q;
   logic [SRAM_ADDRESS_SIZE-1:0] addr_q;
   logic [31:0]                  din_q;
   logic [1:0]                   ack_q;
   logic                         grant_q;
   logic                         we_q;
   logic                         macro_q;

   logic                    grant;
   logic                    any_req;
   logic                    leave_idle;
   logic                    sel_we;
   logic [ADDRESS_BITS-1:0] sel_address;
   logic [3:0]              sel_wmask;
   logic [31:0]             sel_data;
   logic [31:0]             read_half;

   assign leave_idle = (state_q == IDLE) && any_req;

   video_rr_picker2 u_picker (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .valid0_i (req0_valid),
      .valid1_i (req1_valid),
      .update_i (leave_idle),
      .grant_o  (grant),
      .any_o    (any_req)
   );

   assign sel_we      = grant ? req1_we        : req0_we;
   assign sel_address = grant ? req1_address   : req0_address;
   assign sel_wmask   = grant ? req1_wmask     : req0_wmask;
   assign sel_data    = grant ? req1_dataWrite : req0_dataWrite;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         csb_q   <= 2'b11;
         web_q   <= 1'b1;
         wmask_q <= 4'b0000;
         addr_q  <= '0;
         din_q   <= '0;
         ack_q   <= 2'b00;
         grant_q <= 1'b0;
         we_q    <= 1'b0;
         macro_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q <= grant;
                  we_q    <= sel_we;
                  macro_q <= sel_address[MSEL];
                  csb_q   <= sel_address[MSEL] ? 2'b01 : 2'b10;
                  web_q   <= ~sel_we;
                  wmask_q <= sel_wmask;
                  addr_q  <= sel_address[SRAM_ADDRESS_SIZE-1:0];
                  din_q   <= sel_data;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               csb_q   <= 2'b11;
               web_q   <= 1'b1;
               wmask_q <= 4'b0000;
               ack_q   <= grant_q ? 2'b10 : 2'b01;
               state_q <= RESPOND;
            end
            RESPOND: begin
               ack_q   <= 2'b00;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The macro returns data the cycle after its select, i.e. while ack is high.
   assign read_half = macro_q ? sram_dout0[63:32] : sram_dout0[31:0];

   assign req0_ack      = ack_q[0];
   assign req1_ack      = ack_q[1];
   assign req0_dataRead = (ack_q[0] && !we_q) ? read_half : 32'h0;
   assign req1_dataRead = (ack_q[1] && !we_q) ? read_half : 32'h0;
   assign req0_busy     = req0_valid & ~ack_q[0];
   assign req1_busy     = req1_valid & ~ack_q[1];

   assign sram_csb0   = csb_q;
   assign sram_web0   = web_q;
   assign sram_wmask0 = wmask_q;
   assign sram_addr0  = addr_q;
   assign sram_din0   = din_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_video_sram_arbiter.sv
// Directed bench for video_sram_arbiter: a per-cycle vector table for single
// accesses plus hand sequences for idle, contention and reset-in-ACCESS.
module tb_video_sram_arbiter;

`ifdef ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam logic [63:0] DOUT = {32'hCAFEF00D, 32'h5555AAAA};
   localparam int NV = 13;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [9:0]  req0_address = '0;
   logic [3:0]  req0_wmask = '0;
   logic [31:0] req0_dataWrite = '0;
   logic        req0_ack, req0_busy;
   logic [31:0] req0_dataRead;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [9:0]  req1_address = '0;
   logic [3:0]  req1_wmask = '0;
   logic [31:0] req1_dataWrite = '0;
   logic        req1_ack, req1_busy;
   logic [31:0] req1_dataRead;
   logic [1:0]  sram_csb0;
   logic        sram_web0;
   logic [3:0]  sram_wmask0;
   logic [8:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [63:0] sram_dout0 = DOUT;
   logic [1:0]  dbg_state_o;

   video_sram_arbiter dut (
      .wb_clk_i       (wb_clk_i),
      .wb_rst_i       (wb_rst_i),
      .req0_valid     (req0_valid),
      .req0_we        (req0_we),
      .req0_address   (req0_address),
      .req0_wmask     (req0_wmask),
      .req0_dataWrite (req0_dataWrite),
      .req0_ack       (req0_ack),
      .req0_dataRead  (req0_dataRead),
      .req0_busy      (req0_busy),
      .req1_valid     (req1_valid),
      .req1_we        (req1_we),
      .req1_address   (req1_address),
      .req1_wmask     (req1_wmask),
      .req1_dataWrite (req1_dataWrite),
      .req1_ack       (req1_ack),
      .req1_dataRead  (req1_dataRead),
      .req1_busy      (req1_busy),
      .sram_csb0      (sram_csb0),
      .sram_web0      (sram_web0),
      .sram_wmask0    (sram_wmask0),
      .sram_addr0     (sram_addr0),
      .sram_din0      (sram_din0),
      .sram_dout0     (sram_dout0),
      .dbg_state_o    (dbg_state_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic        rst;
      logic [1:0]  v;
      logic [1:0]  we;
      logic [9:0]  a0, a1;
      logic [3:0]  m0, m1;
      logic [31:0] d0, d1;
      logic [1:0]  e_csb;
      logic        e_web;
      logic [3:0]  e_wm;
      logic [8:0]  e_addr;
      logic [31:0] e_din;
      logic [1:0]  e_ack;
      logic [31:0] e_rd0, e_rd1;
      logic [1:0]  e_busy;
   } vec_t;

   vec_t       vecs[NV];
   logic [1:0] exp_q[$];
   int         n_vec  = 0;
   int         n_fail = 0;

   task automatic set_in(input int i, input logic rst, input logic [1:0] v, input logic [1:0] we,
                         input logic [9:0] a0, input logic [9:0] a1, input logic [3:0] m0,
                         input logic [3:0] m1, input logic [31:0] d0, input logic [31:0] d1);
      vecs[i].rst = rst; vecs[i].v = v; vecs[i].we = we;
      vecs[i].a0 = a0; vecs[i].a1 = a1; vecs[i].m0 = m0; vecs[i].m1 = m1;
      vecs[i].d0 = d0; vecs[i].d1 = d1;
   endtask

   task automatic set_exp(input int i, input logic [1:0] csb, input logic web, input logic [3:0] wm,
                          input logic [8:0] addr, input logic [31:0] din, input logic [1:0] ack,
                          input logic [31:0] rd0, input logic [31:0] rd1, input logic [1:0] busy);
      vecs[i].e_csb = csb; vecs[i].e_web = web; vecs[i].e_wm = wm; vecs[i].e_addr = addr;
      vecs[i].e_din = din; vecs[i].e_ack = ack; vecs[i].e_rd0 = rd0; vecs[i].e_rd1 = rd1;
      vecs[i].e_busy = busy;
   endtask

   task automatic cyc();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] pack_out();
      return {12'b0, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
              req1_ack, req0_ack, req0_dataRead, req1_dataRead, req1_busy, req0_busy};
   endfunction

   function automatic logic [127:0] pack_exp(input vec_t x);
      return {12'b0, x.e_csb, x.e_web, x.e_wm, x.e_addr, x.e_din,
              x.e_ack, x.e_rd0, x.e_rd1, x.e_busy};
   endfunction

   initial begin
      // Reset row, read req0 @205 (macro 1), write req1 @012, read req0 @0A3 with address change.
      set_in( 0, 1, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(0, 2'b11, 1, 4'h0, 9'h000, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
      set_in( 1, 0, 2'b01, 2'b00, 10'h205, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(1, 2'b11, 1, 4'h0, 9'h000, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01);
      set_in( 2, 0, 2'b01, 2'b00, 10'h205, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(2, 2'b01, 1, 4'h0, 9'h005, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01);
      set_in( 3, 0, 2'b01, 2'b00, 10'h205, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(3, 2'b11, 1, 4'h0, 9'h005, 32'h0, 2'b01, 32'hCAFEF00D, 32'h0, 2'b00);
      set_in( 4, 0, 2'b00, 2'b00, 10'h205, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(4, 2'b11, 1, 4'h0, 9'h005, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
      set_in( 5, 0, 2'b10, 2'b10, 10'h000, 10'h012, 4'h0, 4'b0011, 32'h0, 32'h12345678);
      set_exp(5, 2'b11, 1, 4'h0, 9'h005, 32'h0, 2'b00, 32'h0, 32'h0, 2'b10);
      set_in( 6, 0, 2'b10, 2'b10, 10'h000, 10'h012, 4'h0, 4'b0011, 32'h0, 32'h12345678);
      set_exp(6, 2'b10, 0, 4'b0011, 9'h012, 32'h12345678, 2'b00, 32'h0, 32'h0, 2'b10);
      set_in( 7, 0, 2'b10, 2'b10, 10'h000, 10'h012, 4'h0, 4'b0011, 32'h0, 32'h12345678);
      set_exp(7, 2'b11, 1, 4'h0, 9'h012, 32'h12345678, 2'b10, 32'h0, 32'h0, 2'b00);
      set_in( 8, 0, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(8, 2'b11, 1, 4'h0, 9'h012, 32'h12345678, 2'b00, 32'h0, 32'h0, 2'b00);
      set_in( 9, 0, 2'b01, 2'b00, 10'h0A3, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(9, 2'b11, 1, 4'h0, 9'h012, 32'h12345678, 2'b00, 32'h0, 32'h0, 2'b01);
      set_in( 10, 0, 2'b01, 2'b00, 10'h3FF, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(10, 2'b10, 1, 4'h0, 9'h0A3, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01);
      set_in( 11, 0, 2'b01, 2'b00, 10'h3FF, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(11, 2'b11, 1, 4'h0, 9'h0A3, 32'h0, 2'b01, 32'h5555AAAA, 32'h0, 2'b00);
      set_in( 12, 0, 2'b00, 2'b00, 10'h3FF, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0);
      set_exp(12, 2'b11, 1, 4'h0, 9'h0A3, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);

      wb_rst_i = 1'b1;
      cyc();
      cyc();
      for (int i = 0; i < NV; i++) begin
         cyc();
         wb_rst_i       = vecs[i].rst;
         req0_valid     = vecs[i].v[0];  req1_valid     = vecs[i].v[1];
         req0_we        = vecs[i].we[0]; req1_we        = vecs[i].we[1];
         req0_address   = vecs[i].a0;    req1_address   = vecs[i].a1;
         req0_wmask     = vecs[i].m0;    req1_wmask     = vecs[i].m1;
         req0_dataWrite = vecs[i].d0;    req1_dataWrite = vecs[i].d1;
         @(negedge wb_clk_i);
         chk($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
      end

      // Quiet bus for 20 cycles.
      for (int k = 0; k < 20; k++) begin
         cyc();
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         @(negedge wb_clk_i);
         chk($sformatf("idle%0d", k), {sram_csb0, req1_ack, req0_ack, req1_busy, req0_busy},
             {2'b11, 2'b00, 2'b00});
      end

      // Both requesters continuously valid from a fresh reset.
      cyc();
      wb_rst_i = 1'b1;
      cyc();
      for (int k = 0; k < 12; k++) begin
         if (k == 2 || k == 8)       exp_q.push_back(2'b01);
         else if (k == 5 || k == 11) exp_q.push_back(RR ? 2'b10 : 2'b01);
         else                        exp_q.push_back(2'b00);
      end
      for (int k = 0; k < 12; k++) begin
         logic [1:0] e;
         cyc();
         wb_rst_i = 1'b0;
         req0_valid = 1'b1; req0_we = 1'b0; req0_address = 10'h001;
         req1_valid = 1'b1; req1_we = 1'b0; req1_address = 10'h201;
         @(negedge wb_clk_i);
         e = exp_q.pop_front();
         chk($sformatf("contend_ack%0d", k), {req1_ack, req0_ack}, e);
      end

      // Write interrupted by reset during ACCESS, then re-issued.
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      cyc();
      req0_valid = 1'b1; req0_we = 1'b1; req0_address = 10'h155;
      req0_wmask = 4'b1111; req0_dataWrite = 32'hAAAA5555;
      cyc();
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      chk("rst_access", {sram_csb0, sram_web0, sram_wmask0}, {2'b10, 1'b0, 4'b1111});
      cyc();
      @(negedge wb_clk_i);
      chk("rst_after", {sram_csb0, sram_web0, req1_ack, req0_ack, dbg_state_o},
          {2'b11, 1'b1, 2'b00, 2'b00});
      cyc();
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      chk("reissue_idle", {sram_csb0, req1_ack, req0_ack}, {2'b11, 2'b00});
      cyc();
      @(negedge wb_clk_i);
      chk("reissue_access", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
          {2'b10, 1'b0, 4'b1111, 9'h155, 32'hAAAA5555});
      cyc();
      @(negedge wb_clk_i);
      chk("reissue_ack", {sram_csb0, req1_ack, req0_ack, req0_busy}, {2'b11, 2'b01, 1'b0});
      cyc();
      req0_valid = 1'b0;
      @(negedge wb_clk_i);
      chk("reissue_done", {req1_ack, req0_ack, dbg_state_o}, {2'b00, 2'b00});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
